// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier operand sequencer.
package mul_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/operand_fifo.sv
// Circular operand-pair buffer with occupancy count; push is refused when full,
// pop is ignored when empty.
module operand_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Buffers operand pairs and feeds them one at a time to a sequential multiplier,
// bypassing the multiplier when either operand is zero.
module mul_operand_sequencer
    import mul_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int W     = DEFAULT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic [W-1:0]             mul_a,
    output logic [W-1:0]             mul_b,
    output logic                     mul_start,
    input  logic                     mul_done,
    input  logic [2*W-1:0]           mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           out_product,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               op_count,
    output state_t                   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits for ready, and the payload is held while valid is high.
    state_t                 r_state;
    state_t                 w_next;
    logic                   r_live;
    logic                   r_wait_armed;
    logic [W-1:0]           r_mul_a;
    logic [W-1:0]           r_mul_b;
    logic [2*W-1:0]         r_out_product;
    logic [7:0]             r_op_count;
    logic [2*W-1:0]         w_head;
    logic [W-1:0]           w_head_a;
    logic [W-1:0]           w_head_b;
    logic                   w_head_zero;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [$clog2(DEPTH):0] w_count;

    operand_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({in_a, in_b}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_a    = w_head[2*W-1:W];
    assign w_head_b    = w_head[W-1:0];
    assign w_head_zero = (w_head_a == '0) || (w_head_b == '0);
    // r_live keeps in_ready low through reset and for the release cycle itself.
    assign in_ready    = r_live && !w_full;
    assign w_push      = in_valid && in_ready;
    assign w_pop       = (r_state == S_IDLE) && !w_empty;

    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign out_product = r_out_product;
    assign op_count    = r_op_count;
    assign fifo_count  = w_count;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        mul_start = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_next = w_head_zero ? S_OUT : S_START;
                end
            end
            S_START: begin
                mul_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_armed && mul_done) begin
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // The first WAIT cycle leaves r_wait_armed low so a done left over from the
    // previous operation cannot be captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_live        <= 1'b0;
            r_wait_armed  <= 1'b0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_out_product <= '0;
            r_op_count    <= '0;
        end else begin
            r_live       <= 1'b1;
            r_wait_armed <= (r_state == S_WAIT);
            if (w_pop) begin
                r_mul_a <= w_head_a;
                r_mul_b <= w_head_b;
                if (w_head_zero) begin
                    r_out_product <= '0;
                end
            end
            if ((r_state == S_WAIT) && r_wait_armed && mul_done) begin
                r_out_product <= mul_product;
            end
            if ((r_state == S_OUT) && out_ready) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

endmodule
